// File: rtl/lane_packer.sv
// lane_packer: gathers LANE_W-bit stream elements into a LANES-wide packed
// vector using two ping-pong buffers, so one vector can fill while the
// previous one waits for the downstream consumer.
module lane_packer #(
  parameter int LANE_W = 16,
  parameter int LANES  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [LANE_W-1:0]          in_data,
  input  logic                       in_last,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [LANE_W*LANES-1:0]    out_bus,
  output logic [$clog2(LANES):0]     out_count,
  input  logic                       out_ready
);

  localparam int CNT_W = $clog2(LANES) + 1;
  localparam int IDX_W = $clog2(LANES);

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2
  } buf_state_t;

  buf_state_t        state_q [2];
  buf_state_t        state_d [2];
  logic [CNT_W-1:0]  cnt_q   [2];
  logic [CNT_W-1:0]  cnt_d   [2];
  logic              wr_sel_q, wr_sel_d;
  logic              rd_sel_q, rd_sel_d;
  logic [LANE_W-1:0] lane_q  [2][LANES];

  logic             accept;
  logic             pop;
  logic             closing;
  logic             first;
  logic [IDX_W-1:0] wr_idx;

  // Handshakes depend only on registered buffer state, never on out_ready.
  assign in_ready  = (state_q[wr_sel_q] != FULL);
  assign out_valid = (state_q[rd_sel_q] == FULL);
  assign out_count = cnt_q[rd_sel_q];

  assign accept  = in_valid && in_ready;
  assign pop     = out_valid && out_ready;
  assign first   = (state_q[wr_sel_q] == EMPTY);
  assign wr_idx  = cnt_q[wr_sel_q][IDX_W-1:0];
  // in_last on the final lane is the same single close, not a second one.
  assign closing = in_last || (cnt_q[wr_sel_q] == CNT_W'(LANES - 1));

  // Next-state for both buffers and the ping-pong pointers.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      state_d[b] = state_q[b];
      cnt_d[b]   = cnt_q[b];
    end
    wr_sel_d = wr_sel_q;
    rd_sel_d = rd_sel_q;

    // pop and accept always address different buffers (FULL vs not FULL).
    if (pop) begin
      state_d[rd_sel_q] = EMPTY;
      cnt_d[rd_sel_q]   = '0;
      rd_sel_d          = ~rd_sel_q;
    end

    if (accept) begin
      cnt_d[wr_sel_q] = cnt_q[wr_sel_q] + CNT_W'(1);
      if (closing) begin
        state_d[wr_sel_q] = FULL;
        wr_sel_d          = ~wr_sel_q;
      end else begin
        state_d[wr_sel_q] = FILLING;
      end
    end
  end

  // Control state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        state_q[b] <= EMPTY;
        cnt_q[b]   <= '0;
      end
      wr_sel_q <= 1'b0;
      rd_sel_q <= 1'b0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        state_q[b] <= state_d[b];
        cnt_q[b]   <= cnt_d[b];
      end
      wr_sel_q <= wr_sel_d;
      rd_sel_q <= rd_sel_d;
    end
  end

  // Lane storage; the first element of a vector clears every other lane so
  // a partial vector never exposes data from an earlier one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < LANES; i++) begin
          lane_q[b][i] <= '0;
        end
      end
    end else if (accept) begin
      if (first) begin
        for (int i = 0; i < LANES; i++) begin
          lane_q[wr_sel_q][i] <= (i == 0) ? in_data : '0;
        end
      end else begin
        lane_q[wr_sel_q][wr_idx] <= in_data;
      end
    end
  end

  // Present the read-side buffer as a lane-packed bus.
  always_comb begin
    out_bus = '0;
    for (int i = 0; i < LANES; i++) begin
      out_bus[i*LANE_W +: LANE_W] = lane_q[rd_sel_q][i];
    end
  end

endmodule

// File: tb/tb_lane_packer.sv
// Bench for lane_packer: scoreboard of expected vectors filled as elements are
// accepted, drained by a monitor on every output transfer.
module tb_lane_packer;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic [15:0]  in_data = '0;
  logic         in_last = 1'b0;
  logic         in_ready;
  logic         out_valid;
  logic [255:0] out_bus;
  logic [4:0]   out_count;
  logic         out_ready = 1'b0;

  lane_packer #(.LANE_W(16), .LANES(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_bus   (out_bus),
    .out_count (out_count),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [255:0] bus;
    logic [4:0]   cnt;
  } exp_t;

  exp_t        q[$];
  logic [15:0] tb_lane [16];
  int          tb_cnt = 0;
  int          n_vec  = 0;
  int          n_err  = 0;
  bit          stalled = 1'b0;

  // Monitor: every output transfer is checked against the scoreboard head.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      n_vec++;
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_vector: got bus=%h count=%0d, none expected", out_bus, out_count);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (out_bus !== e.bus || out_count !== e.cnt) begin
          n_err++;
          $display("FAIL vector: got bus=%h count=%0d, want bus=%h count=%0d",
                   out_bus, out_count, e.bus, e.cnt);
        end
      end
    end
  end

  task automatic model_push(input logic [15:0] d, input bit last);
    exp_t e;
    tb_lane[tb_cnt] = d;
    tb_cnt++;
    if (last || tb_cnt == 16) begin
      e.bus = '0;
      for (int i = 0; i < tb_cnt; i++) e.bus[i*16 +: 16] = tb_lane[i];
      e.cnt = 5'(tb_cnt);
      q.push_back(e);
      tb_cnt = 0;
    end
  endtask

  // Offer one element and hold it until accepted; returns at posedge+1.
  task automatic send(input logic [15:0] d, input bit last);
    bit ok;
    int guard;
    guard    = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    forever begin
      @(negedge clk);
      ok = in_ready;
      if (!ok) stalled = 1'b1;
      @(posedge clk);
      #1;
      if (ok) break;
      guard++;
      if (guard > 200) begin
        n_vec++;
        n_err++;
        $display("FAIL send_timeout: element %h not accepted, want accept within 200 cycles", d);
        break;
      end
    end
    if (ok) model_push(d, last);
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (q.size() != 0 && guard < 300) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: %0d vectors outstanding, want 0", q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    n_vec++; if (out_bus !== 256'h0) begin n_err++; $display("FAIL rst_out_bus: got %h want 0", out_bus); end
    n_vec++; if (out_count !== 5'd0) begin n_err++; $display("FAIL rst_out_count: got %0d want 0", out_count); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_full_vector();
    logic [15:0] sum;
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) send(16'h0010, 1'b0);
    idle();
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL full_latency: out_valid got %b want 1", out_valid); end
    sum = '0;
    for (int i = 0; i < 16; i++) sum = sum + out_bus[i*16 +: 16];
    n_vec++; if (sum !== 16'h0100) begin n_err++; $display("FAIL full_sum: got %h want 0100", sum); end
    drain();
  endtask

  task automatic test_partial();
    out_ready = 1'b1;
    send(16'd2, 1'b0);
    send(16'd3, 1'b1);
    idle();
    n_vec++; if (out_count !== 5'd2) begin n_err++; $display("FAIL partial_count: got %0d want 2", out_count); end
    drain();
    send(16'd7, 1'b1);
    idle();
    drain();
  endtask

  task automatic test_backpressure();
    logic [255:0] vec_a, vec_b;
    for (int i = 0; i < 16; i++) begin
      vec_a[i*16 +: 16] = 16'(i);
      vec_b[i*16 +: 16] = 16'(i + 16);
    end
    out_ready = 1'b0;
    for (int i = 0; i < 32; i++) send(16'(i), 1'b0);
    in_data = 16'd32;
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready_low: got %b want 0", in_ready); end
    idle();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_vec++; if (out_bus !== vec_a) begin n_err++; $display("FAIL bp_hold: got %h want %h", out_bus, vec_a); end
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    n_vec++; if (out_bus !== vec_b) begin n_err++; $display("FAIL bp_switch: got %h want %h", out_bus, vec_b); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_in_ready_back: got %b want 1", in_ready); end
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_second_valid: got %b want 1", out_valid); end
    out_ready = 1'b1;
    for (int i = 32; i < 41; i++) send(16'(i), i == 40);
    idle();
    drain();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    stalled   = 1'b0;
    for (int i = 0; i < 48; i++) send(16'(i), 1'b0);
    idle();
    n_vec++; if (stalled !== 1'b0) begin n_err++; $display("FAIL stream_in_ready: stalled got %b want 0", stalled); end
    drain();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    for (int i = 0; i < 23; i++) send(16'(i + 1), 1'b0);
    idle();
    #2;
    rst = 1'b1;
    #1;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_valid: got %b want 0", out_valid); end
    n_vec++; if (out_bus !== 256'h0) begin n_err++; $display("FAIL mid_rst_bus: got %h want 0", out_bus); end
    n_vec++; if (out_count !== 5'd0) begin n_err++; $display("FAIL mid_rst_count: got %0d want 0", out_count); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL mid_rst_in_ready: got %b want 1", in_ready); end
    q.delete();
    tb_cnt = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) send(16'(16'h0A00 + i), 1'b0);
    idle();
    drain();
    repeat (3) @(posedge clk);
    #1;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_extra: out_valid got %b want 0", out_valid); end
  endtask

  task automatic test_edges();
    out_ready = 1'b1;
    send(16'hABCD, 1'b1);
    idle();
    n_vec++; if (out_count !== 5'd1) begin n_err++; $display("FAIL last_first_count: got %0d want 1", out_count); end
    n_vec++; if (out_bus !== {240'h0, 16'hABCD}) begin n_err++; $display("FAIL last_first_bus: got %h want lane0 abcd only", out_bus); end
    drain();
    in_valid = 1'b0;
    in_last  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL last_no_valid: out_valid got %b want 0", out_valid); end
    end
    @(posedge clk);
    #1;
    in_last = 1'b0;
    for (int i = 0; i < 16; i++) send(16'(16'h0100 + i), i == 15);
    send(16'h0055, 1'b1);
    idle();
    drain();
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL last16_single_close: out_valid got %b want 0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_full_vector();
    test_partial();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_edges();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lane_packer.md
# lane_packer

Stream-to-vector packer that sits directly upstream of the 16-lane `sum` reduction stage. It accepts 16-bit elements one per cycle over a valid/ready stream and assembles them into a 256-bit lane-packed bus. It presents each completed vector with a valid/ready handshake. Two ping-pong buffers let one vector be filled while the previous one waits for the consumer.

## Interface
- `LANE_W`, 16, width of one element/lane in bits
- `LANES`, 16, lanes per vector; output bus width is `LANE_W*LANES` (256)

- `clk`  in  1  single clock, rising-edge
- `rst`  in  1  asynchronous, active-high reset
- `in_valid`  in  1  element present on `in_data`
- `in_data`  in  LANE_W  element value
- `in_last`  in  1  element closes the current vector (partial flush)
- `in_ready`  out  1  packer can accept an element this cycle
- `out_valid`  out  1  `out_bus` holds a complete vector
- `out_bus`  out  LANE_W*LANES  packed vector; lane i at bits [LANE_W*i+LANE_W-1 : LANE_W*i]
- `out_count`  out  $clog2(LANES)+1  number of filled lanes (1..LANES)
- `out_ready`  in  1  consumer takes vector this cycle

## Operation
- Input transfer: `in_valid && in_ready` at a rising edge. Output transfer: `out_valid && out_ready`.
- Two buffers, B0/B1. Each is EMPTY, FILLING or FULL, with its own lane counter. The write pointer `wr_sel` and read pointer `rd_sel` start at B0.
- Filling: the first accepted element goes to lane 0, the next to lane 1, and so on. The first element of a vector zero-clears all other lanes of that buffer, so unused lanes always read 0.
- Close: a buffer becomes FULL after accepting its LANES-th element, or any element carrying `in_last`.
  - `in_last` on the LANES-th element closes only once.
  - `in_last` on the first element gives `out_count` = 1.
  - When a buffer closes, `wr_sel` toggles.
- `in_ready` = buffer[`wr_sel`] not FULL. It is combinational from registered state only; there is no path from `out_ready`.
- `out_valid` = buffer[`rd_sel`] FULL. `out_bus` and `out_count` come from buffer[`rd_sel`].
  - While `out_valid && !out_ready`, `out_bus` and `out_count` are held stable.
- When an output transfer occurs, buffer[`rd_sel`] becomes EMPTY and `rd_sel` toggles at that edge.
- Vectors are delivered strictly in fill order. An empty vector is never emitted: `in_last` without `in_valid` is ignored.
- Width: `out_count` holds values up to LANES inclusive. Data is passed through unmodified, with no arithmetic.

## Timing
- Reset (async assert, sync-safe release):
  - both buffers EMPTY and zeroed, `wr_sel` = `rd_sel` = B0
  - `out_valid` = 0, `out_bus` = 0, `out_count` = 0, `in_ready` = 1
- Reset asserted mid-fill or mid-hold discards all buffered data. Outputs take reset values immediately, without waiting for a clock edge.
- Latency: the closing element is accepted at edge t, and `out_valid` = 1 in the cycle after edge t.
- Throughput: with `out_ready` held high, one element per cycle is sustained indefinitely and `in_ready` never deasserts.
- Both buffers FULL: `in_ready` = 0.
  - An output transfer at edge t frees a buffer, and `in_ready` = 1 in the cycle after t.
- Input close and output transfer on the same edge (different buffers): both take effect, with no lost or duplicated vector.
- An input is never accepted into a buffer that is FULL at that edge. A freed buffer becomes writable only from the following cycle.

## Test plan
- Full vector: 16 elements of 0x0010 back-to-back, `out_ready` = 1.
  - `out_valid` one cycle after the 16th element.
  - `out_bus` = {16{16'h0010}}, `out_count` = 16.
  - Feeding this into `sum` gives 0x0100.
- Partial flush: elements 2 then 3 (`in_last` on 3).
  - `out_bus` = {224'h0, 16'd3, 16'd2}, `out_count` = 2.
  - Next vector's lanes 2..15 read 0 even after prior nonzero data.
- Backpressure: `out_ready` = 0, stream elements 0..40.
  - `in_ready` drops after element 31 is accepted; `out_bus` stays stable holding 0..15.
  - Pulse `out_ready` for one cycle: `out_bus` switches to 16..31, and `in_ready` = 1 the next cycle.
- Streaming: 48 elements 0..47 continuous with `out_ready` = 1.
  - Three vectors in order, `in_ready` never low.
  - Lane 0 values are 0, 16, 32.
- Reset mid-operation: assert `rst` after 7 elements are accepted and one FULL vector is pending.
  - Outputs go to reset values immediately.
  - After release, 16 fresh elements produce exactly one vector with no stale data.
- Edge cases:
  - `in_last` on the first element gives `out_count` = 1 and lane 0 only.
  - `in_last` with `in_valid` = 0 produces no output.
